// File: rtl/uart_boot_sequencer.sv
// UART boot loader: parses a MAGIC-framed image from an RX byte stream, writes it
// word by word into memory, verifies the checksum and releases the CPU from reset.
module uart_boot_sequencer #(
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_bits,
  output logic        io_rx_ready,
  output logic        io_mem_valid,
  output logic [31:0] io_mem_addr,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wstrb,
  input  logic        io_mem_ready,
  output logic        io_cpu_reset,
  output logic        io_done,
  output logic        io_error,
  output logic [1:0]  io_err_code
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [15:0] count_reg, count_next;
  logic [7:0]  csum_reg, csum_next;
  logic [1:0]  byte_reg, byte_next;
  logic [31:0] tmo_reg, tmo_next;
  logic [1:0]  err_reg, err_next;

  logic rx_fire;
  logic timed;

  // Every output is a register or a pure decode of the state register.
  assign io_rx_ready  = (state_reg != WRITE);
  assign io_mem_valid = (state_reg == WRITE);
  assign io_mem_addr  = addr_reg;
  assign io_mem_wdata = wdata_reg;
  assign io_cpu_reset = (state_reg != DONE);
  assign io_done      = (state_reg == DONE);
  assign io_error     = (state_reg == ERROR);
  assign io_err_code  = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strb
      assign io_mem_wstrb[gi] = io_mem_valid;
    end
  endgenerate

  assign rx_fire = io_rx_valid && io_rx_ready;
  assign timed   = (state_reg == ADDR) || (state_reg == LEN) ||
                   (state_reg == DATA) || (state_reg == CSUM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      count_reg <= 16'd0;
      csum_reg  <= 8'd0;
      byte_reg  <= 2'd0;
      tmo_reg   <= 32'd0;
      err_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      count_reg <= count_next;
      csum_reg  <= csum_next;
      byte_reg  <= byte_next;
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    count_next = count_reg;
    csum_next  = csum_reg;
    byte_next  = byte_reg;
    tmo_next   = tmo_reg;
    err_next   = err_reg;

    if (timed) begin
      tmo_next = rx_fire ? 32'd0 : tmo_reg + 32'd1;
    end

    case (state_reg)
      IDLE, ERROR: begin
        if (rx_fire && (io_rx_bits == MAGIC)) begin
          state_next = ADDR;
          csum_next  = 8'd0;
          byte_next  = 2'd0;
          tmo_next   = 32'd0;
          err_next   = 2'd0;
        end
      end

      ADDR: begin
        if (rx_fire) begin
          addr_next[{byte_reg, 3'b000} +: 8] = io_rx_bits;
          addr_next[1:0] = 2'b00;
          csum_next = csum_reg + io_rx_bits;
          byte_next = byte_reg + 2'd1;
          if (byte_reg == 2'd3) begin
            state_next = LEN;
            byte_next  = 2'd0;
          end
        end
      end

      LEN: begin
        if (rx_fire) begin
          csum_next = csum_reg + io_rx_bits;
          if (byte_reg == 2'd0) begin
            count_next[7:0] = io_rx_bits;
            byte_next       = 2'd1;
          end else begin
            count_next[15:8] = io_rx_bits;
            byte_next        = 2'd0;
            state_next = ({io_rx_bits, count_reg[7:0]} != 16'd0) ? DATA : CSUM;
          end
        end
      end

      DATA: begin
        if (rx_fire) begin
          wdata_next[{byte_reg, 3'b000} +: 8] = io_rx_bits;
          csum_next = csum_reg + io_rx_bits;
          byte_next = byte_reg + 2'd1;
          if (byte_reg == 2'd3) begin
            state_next = WRITE;
            byte_next  = 2'd0;
          end
        end
      end

      WRITE: begin
        if (io_mem_ready) begin
          addr_next  = addr_reg + 32'd4;
          count_next = count_reg - 16'd1;
          state_next = (count_reg == 16'd1) ? CSUM : DATA;
        end
      end

      CSUM: begin
        if (rx_fire) begin
          if (io_rx_bits == csum_reg) begin
            state_next = DONE;
          end else begin
            state_next = ERROR;
            err_next   = 2'd1;
          end
        end
      end

      default: begin
        // DONE: bytes are drained without effect until reset.
      end
    endcase

    // Idle-gap limit only matters while no byte arrives this cycle.
    if (timed && !rx_fire && (tmo_reg == TMO_LAST)) begin
      state_next = ERROR;
      err_next   = 2'd3;
      tmo_next   = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Directed bench for uart_boot_sequencer: framed loads, checksum error, stalls,
// timeout, garbage filtering and asynchronous reset in the middle of a write.
module tb_uart_boot_sequencer;

  localparam int TMO = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_rx_valid;
  logic [7:0]  io_rx_bits;
  logic        io_rx_ready;
  logic        io_mem_valid;
  logic [31:0] io_mem_addr;
  logic [31:0] io_mem_wdata;
  logic [3:0]  io_mem_wstrb;
  logic        io_mem_ready;
  logic        io_cpu_reset;
  logic        io_done;
  logic        io_error;
  logic [1:0]  io_err_code;

  int total = 0;
  int bad   = 0;

  logic [31:0] log_a [32];
  logic [31:0] log_d [32];
  int          wr_n = 0;
  int          wr_base = 0;
  int          stall_req = 0;
  bit          stall_chk = 1'b0;
  logic [31:0] exp_a [4];
  logic [31:0] exp_d [4];
  int          drv_cyc = 0;
  bit          drv_hs = 1'b0;

  // Frame from the reference load: two words at 0x1000, checksum 0x76.
  logic [7:0] fa [16] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
                          8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h76};
  logic [7:0] fz [8]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80};
  // Two words starting at 0xFFFFFFFC: second write wraps to 0, checksum 0xFE.
  logic [7:0] fw [16] = '{8'hA5, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
                          8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFE};
  // Unaligned address 0x1003 must load at 0x1000, checksum 0x4C.
  logic [7:0] fu [12] = '{8'hA5, 8'h03, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00,
                          8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h4C};
  logic [7:0] garbage [3] = '{8'h00, 8'hFF, 8'h5A};

  uart_boot_sequencer #(.MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rx_valid  (io_rx_valid),
    .io_rx_bits   (io_rx_bits),
    .io_rx_ready  (io_rx_ready),
    .io_mem_valid (io_mem_valid),
    .io_mem_addr  (io_mem_addr),
    .io_mem_wdata (io_mem_wdata),
    .io_mem_wstrb (io_mem_wstrb),
    .io_mem_ready (io_mem_ready),
    .io_cpu_reset (io_cpu_reset),
    .io_done      (io_done),
    .io_error     (io_error),
    .io_err_code  (io_err_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    io_rx_valid = 1'b1;
    io_rx_bits  = b;
    while (!io_rx_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("rx_ready_wait", {31'd0, io_rx_ready}, 32'd1);
    @(posedge clock);
    #1;
    io_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wr_base = wr_n;
  endtask

  // Write log: one line per accepted memory write.
  always @(posedge clock) begin
    if (!reset && io_mem_valid && io_mem_ready) begin
      if (wr_n < 32) begin
        log_a[wr_n] <= io_mem_addr;
        log_d[wr_n] <= io_mem_wdata;
      end
      wr_n <= wr_n + 1;
      chk("wstrb", {28'd0, io_mem_wstrb}, 32'hF);
      $display("write #%0d addr=%08h data=%08h strb=%h", wr_n, io_mem_addr, io_mem_wdata, io_mem_wstrb);
    end
  end

  // Memory responder: stalls each write for stall_req cycles, then accepts.
  initial begin
    io_mem_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (drv_hs) chk("valid_drop", {31'd0, io_mem_valid}, 32'd0);
      drv_hs = 1'b0;
      if (io_mem_valid) begin
        if (drv_cyc < stall_req) begin
          io_mem_ready = 1'b0;
          drv_cyc++;
          if (stall_chk && (wr_n - wr_base) < 4) begin
            chk("stall_addr", io_mem_addr, exp_a[wr_n - wr_base]);
            chk("stall_data", io_mem_wdata, exp_d[wr_n - wr_base]);
            chk("stall_rx_ready", {31'd0, io_rx_ready}, 32'd0);
            chk("stall_no_err", {30'd0, io_err_code}, 32'd0);
          end
        end else begin
          io_mem_ready = 1'b1;
          drv_hs = 1'b1;
        end
      end else begin
        io_mem_ready = 1'b0;
        drv_cyc = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io_rx_valid = 1'b0;
    io_rx_bits  = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_cpu_reset", {31'd0, io_cpu_reset}, 32'd1);
    chk("rst_mem_valid", {31'd0, io_mem_valid}, 32'd0);
    chk("rst_done", {31'd0, io_done}, 32'd0);
    chk("rst_error", {31'd0, io_error}, 32'd0);
    chk("rst_err_code", {30'd0, io_err_code}, 32'd0);
    chk("rst_rx_ready", {31'd0, io_rx_ready}, 32'd1);
    chk("rst_addr", io_mem_addr, 32'd0);
    chk("rst_wdata", io_mem_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, io_mem_wstrb}, 32'd0);
    reset = 1'b0;
    wr_base = wr_n;

    // Garbage then an empty (N=0) frame.
    for (int i = 0; i < 3; i++) send_byte(garbage[i]);
    chk("garbage_done", {31'd0, io_done}, 32'd0);
    chk("garbage_rx_ready", {31'd0, io_rx_ready}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(fz[i]);
    chk("zero_done", {31'd0, io_done}, 32'd1);
    chk("zero_cpu_reset", {31'd0, io_cpu_reset}, 32'd0);
    send_byte(8'hA5);
    repeat (3) @(posedge clock);
    #1;
    chk("zero_writes", 32'(wr_n - wr_base), 32'd0);
    chk("done_sticky", {31'd0, io_done}, 32'd1);

    // Bad checksum, then a correct frame recovers.
    do_reset();
    for (int i = 0; i < 15; i++) send_byte(fa[i]);
    send_byte(8'h77);
    chk("bad_error", {31'd0, io_error}, 32'd1);
    chk("bad_err_code", {30'd0, io_err_code}, 32'd1);
    chk("bad_cpu_reset", {31'd0, io_cpu_reset}, 32'd1);
    chk("bad_writes", 32'(wr_n - wr_base), 32'd2);
    chk("bad_a0", log_a[wr_base], 32'h0000_1000);
    chk("bad_d0", log_d[wr_base], 32'h4433_2211);
    chk("bad_a1", log_a[wr_base + 1], 32'h0000_1004);
    chk("bad_d1", log_d[wr_base + 1], 32'h8877_6655);
    for (int i = 0; i < 16; i++) send_byte(fa[i]);
    chk("good_done", {31'd0, io_done}, 32'd1);
    chk("good_cpu_reset", {31'd0, io_cpu_reset}, 32'd0);
    chk("good_error", {31'd0, io_error}, 32'd0);
    chk("good_err_code", {30'd0, io_err_code}, 32'd0);
    chk("good_writes", 32'(wr_n - wr_base), 32'd4);
    chk("good_a0", log_a[wr_base + 2], 32'h0000_1000);
    chk("good_d1", log_d[wr_base + 3], 32'h8877_6655);

    // Memory stalls 20 cycles on each write.
    do_reset();
    exp_a[0] = 32'h0000_1000;  exp_d[0] = 32'h4433_2211;
    exp_a[1] = 32'h0000_1004;  exp_d[1] = 32'h8877_6655;
    stall_req = 20;
    stall_chk = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(fa[i]);
    stall_chk = 1'b0;
    stall_req = 0;
    chk("stall_done", {31'd0, io_done}, 32'd1);
    chk("stall_writes", 32'(wr_n - wr_base), 32'd2);
    chk("stall_a1", log_a[wr_base + 1], 32'h0000_1004);
    chk("stall_d1", log_d[wr_base + 1], 32'h8877_6655);

    // Timeout after two address bytes, then recovery with a wrapping frame.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (99) @(posedge clock);
    #1;
    chk("tmo_early_code", {30'd0, io_err_code}, 32'd0);
    chk("tmo_early_error", {31'd0, io_error}, 32'd0);
    @(posedge clock);
    #1;
    chk("tmo_code", {30'd0, io_err_code}, 32'd3);
    chk("tmo_error", {31'd0, io_error}, 32'd1);
    chk("tmo_cpu_reset", {31'd0, io_cpu_reset}, 32'd1);
    wr_base = wr_n;
    for (int i = 0; i < 16; i++) send_byte(fw[i]);
    chk("wrap_done", {31'd0, io_done}, 32'd1);
    chk("wrap_err_code", {30'd0, io_err_code}, 32'd0);
    chk("wrap_writes", 32'(wr_n - wr_base), 32'd2);
    chk("wrap_a0", log_a[wr_base], 32'hFFFF_FFFC);
    chk("wrap_d0", log_d[wr_base], 32'h0000_0001);
    chk("wrap_a1", log_a[wr_base + 1], 32'h0000_0000);
    chk("wrap_d1", log_d[wr_base + 1], 32'h0000_0002);

    // Asynchronous reset while a write is pending.
    do_reset();
    stall_req = 1000;
    for (int i = 0; i < 11; i++) send_byte(fa[i]);
    chk("pend_valid", {31'd0, io_mem_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, io_mem_valid}, 32'd0);
    chk("arst_cpu_reset", {31'd0, io_cpu_reset}, 32'd1);
    chk("arst_rx_ready", {31'd0, io_rx_ready}, 32'd1);
    chk("arst_addr", io_mem_addr, 32'd0);
    chk("arst_wdata", io_mem_wdata, 32'd0);
    chk("arst_wstrb", {28'd0, io_mem_wstrb}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    stall_req = 0;
    wr_base = wr_n;
    for (int i = 0; i < 12; i++) send_byte(fu[i]);
    chk("post_done", {31'd0, io_done}, 32'd1);
    chk("post_writes", 32'(wr_n - wr_base), 32'd1);
    chk("post_addr", log_a[wr_base], 32'h0000_1000);
    chk("post_data", log_d[wr_base], 32'hEFBE_ADDE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
